fetch_redirect_arbiter: RTL and testbench

Collects PC redirect requests from four sources: commit flush, branch mispredict, decode invalid-instruction and decode return. It resolves them by fixed priority and holds the winner until the fetch stage can accept it, then issues one registered redirect. Each issued redirect advances a fetch epoch so downstream stages can discard stale packets. It sits between the backend and decode redirect sources on one side and the fetch PC logic on the other, and replaces per-source override handling in fetch.

---
 rtl/fetch_redirect_arbiter.sv | 125 ++++++++++++
 tb/tb_fetch_redirect_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_arbiter.sv
// rtl/fetch_redirect_arbiter.sv - fixed-priority PC redirect arbiter with fetch epoch and drop counter
module fetch_redirect_arbiter #(
    parameter int PC_BITS    = 32,
    parameter int EPOCH_BITS = 3,
    parameter int DROP_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_valid_i,
    input  logic [PC_BITS-1:0]    flush_pc_i,
    input  logic                  mispred_valid_i,
    input  logic [PC_BITS-1:0]    mispred_pc_i,
    input  logic                  invinstr_valid_i,
    input  logic [PC_BITS-1:0]    invinstr_pc_i,
    input  logic                  ret_valid_i,
    input  logic [PC_BITS-1:0]    ret_pc_i,
    input  logic                  fetch_idle_i,
    output logic                  redir_valid_o,
    output logic [PC_BITS-1:0]    redir_pc_o,
    output logic [1:0]            redir_src_o,
    output logic                  fetch_hold_o,
    output logic [EPOCH_BITS-1:0] epoch_o,
    output logic [DROP_BITS-1:0]  drop_cnt_o
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    state_t               state;
    logic [PC_BITS-1:0]   pend_pc;
    logic [1:0]           pend_src;

    logic                 in_valid;
    logic [PC_BITS-1:0]   in_pc;
    logic [1:0]           in_src;
    logic [2:0]           n_valid;
    logic [2:0]           drops;
    logic                 take_in;
    logic                 drop_in;
    logic                 issue;
    logic [DROP_BITS:0]   drop_sum;

    localparam logic [DROP_BITS:0] DROP_MAX = {1'b0, {DROP_BITS{1'b1}}};

    always_comb begin
        in_valid = 1'b1;
        in_pc    = '0;
        in_src   = 2'd0;
        if (flush_valid_i) begin
            in_pc  = flush_pc_i;
            in_src = 2'd3;
        end else if (mispred_valid_i) begin
            in_pc  = mispred_pc_i;
            in_src = 2'd2;
        end else if (invinstr_valid_i) begin
            in_pc  = invinstr_pc_i;
            in_src = 2'd1;
        end else if (ret_valid_i) begin
            in_pc  = ret_pc_i;
            in_src = 2'd0;
        end else begin
            in_valid = 1'b0;
        end
    end

    assign issue = (state == S_PENDING) && fetch_idle_i;

    // Replacement of an older pending redirect is not a drop; only rejected
    // incoming requests and same-cycle losers are counted.
    always_comb begin
        take_in = 1'b0;
        drop_in = 1'b0;
        if (state == S_IDLE) begin
            take_in = in_valid;
        end else if (!fetch_idle_i) begin
            if (in_valid && ((in_src > pend_src) || (in_src == 2'd3 && pend_src == 2'd3)))
                take_in = 1'b1;
            else
                drop_in = in_valid;
        end else begin
            take_in = in_valid && (in_src >= pend_src);
            drop_in = in_valid && (in_src < pend_src);
        end
    end

    assign n_valid  = {2'b00, flush_valid_i} + {2'b00, mispred_valid_i}
                    + {2'b00, invinstr_valid_i} + {2'b00, ret_valid_i};
    assign drops    = (in_valid ? n_valid - 3'd1 : 3'd0) + {2'b00, drop_in};
    assign drop_sum = {1'b0, drop_cnt_o} + {{(DROP_BITS-2){1'b0}}, drops};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pend_pc    <= '0;
            pend_src   <= 2'd0;
            epoch_o    <= '0;
            drop_cnt_o <= '0;
        end else begin
            if (take_in) begin
                state    <= S_PENDING;
                pend_pc  <= in_pc;
                pend_src <= in_src;
            end else if (issue) begin
                state    <= S_IDLE;
                pend_pc  <= '0;
                pend_src <= 2'd0;
            end
            if (issue)
                epoch_o <= epoch_o + 1'b1;
            if (drop_sum > DROP_MAX)
                drop_cnt_o <= {DROP_BITS{1'b1}};
            else
                drop_cnt_o <= drop_sum[DROP_BITS-1:0];
        end
    end

    // pend_pc/pend_src are cleared on return to idle, so they drive outputs directly.
    assign fetch_hold_o  = (state == S_PENDING);
    assign redir_valid_o = (state == S_PENDING) && fetch_idle_i;
    assign redir_pc_o    = pend_pc;
    assign redir_src_o   = pend_src;

endmodule

// File: tb/tb_fetch_redirect_arbiter.sv
// tb/tb_fetch_redirect_arbiter.sv - directed self-checking bench for fetch_redirect_arbiter
module tb_fetch_redirect_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_valid_i = 1'b0, mispred_valid_i = 1'b0, invinstr_valid_i = 1'b0, ret_valid_i = 1'b0;
    logic [31:0] flush_pc_i = '0, mispred_pc_i = '0, invinstr_pc_i = '0, ret_pc_i = '0;
    logic        fetch_idle_i = 1'b0;
    logic        redir_valid_o;
    logic [31:0] redir_pc_o;
    logic [1:0]  redir_src_o;
    logic        fetch_hold_o;
    logic [2:0]  epoch_o;
    logic [7:0]  drop_cnt_o;

    int total = 0;
    int bad = 0;

    fetch_redirect_arbiter #(.PC_BITS(32), .EPOCH_BITS(3), .DROP_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .flush_valid_i(flush_valid_i), .flush_pc_i(flush_pc_i),
        .mispred_valid_i(mispred_valid_i), .mispred_pc_i(mispred_pc_i),
        .invinstr_valid_i(invinstr_valid_i), .invinstr_pc_i(invinstr_pc_i),
        .ret_valid_i(ret_valid_i), .ret_pc_i(ret_pc_i),
        .fetch_idle_i(fetch_idle_i),
        .redir_valid_o(redir_valid_o), .redir_pc_o(redir_pc_o), .redir_src_o(redir_src_o),
        .fetch_hold_o(fetch_hold_o), .epoch_o(epoch_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic clr();
        flush_valid_i = 1'b0; mispred_valid_i = 1'b0; invinstr_valid_i = 1'b0; ret_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; clr(); fetch_idle_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; clr(); fetch_idle_i = 1'b1;
        #1;
        total++; if (redir_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", redir_valid_o); end
        total++; if (redir_pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%0h exp=0", redir_pc_o); end
        total++; if (redir_src_o !== 2'd0) begin bad++; $display("FAIL rst_src got=%0h exp=0", redir_src_o); end
        total++; if (fetch_hold_o !== 1'b0) begin bad++; $display("FAIL rst_hold got=%0h exp=0", fetch_hold_o); end
        total++; if (epoch_o !== 3'd0) begin bad++; $display("FAIL rst_epoch got=%0h exp=0", epoch_o); end
        total++; if (drop_cnt_o !== 8'd0) begin bad++; $display("FAIL rst_drop got=%0h exp=0", drop_cnt_o); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (redir_valid_o !== 1'b0) begin bad++; $display("FAIL rst_idle_valid got=%0h exp=0", redir_valid_o); end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        mispred_valid_i = 1'b1; mispred_pc_i = 32'h100; fetch_idle_i = 1'b1;
        #1;
        total++; if (fetch_hold_o !== 1'b0) begin bad++; $display("FAIL single_hold0 got=%0h exp=0", fetch_hold_o); end
        @(negedge clk); clr(); #1;
        total++; if (redir_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got=%0h exp=1", redir_valid_o); end
        total++; if (redir_pc_o !== 32'h100) begin bad++; $display("FAIL single_pc got=%0h exp=100", redir_pc_o); end
        total++; if (redir_src_o !== 2'd2) begin bad++; $display("FAIL single_src got=%0h exp=2", redir_src_o); end
        total++; if (fetch_hold_o !== 1'b1) begin bad++; $display("FAIL single_hold1 got=%0h exp=1", fetch_hold_o); end
        total++; if (epoch_o !== 3'd0) begin bad++; $display("FAIL single_epoch0 got=%0h exp=0", epoch_o); end
        @(negedge clk); #1;
        total++; if (epoch_o !== 3'd1) begin bad++; $display("FAIL single_epoch1 got=%0h exp=1", epoch_o); end
        total++; if (fetch_hold_o !== 1'b0) begin bad++; $display("FAIL single_hold2 got=%0h exp=0", fetch_hold_o); end
        total++; if (redir_valid_o !== 1'b0) begin bad++; $display("FAIL single_valid2 got=%0h exp=0", redir_valid_o); end
        total++; if (redir_pc_o !== 32'h0) begin bad++; $display("FAIL single_pc2 got=%0h exp=0", redir_pc_o); end
    endtask

    task automatic test_stall_replace();
        do_reset();
        @(negedge clk); fetch_idle_i = 1'b0; ret_valid_i = 1'b1; ret_pc_i = 32'h40;
        @(negedge clk); clr(); mispred_valid_i = 1'b1; mispred_pc_i = 32'h80; #1;
        total++; if (redir_pc_o !== 32'h40) begin bad++; $display("FAIL stall_ret_pc got=%0h exp=40", redir_pc_o); end
        total++; if (redir_valid_o !== 1'b0) begin bad++; $display("FAIL stall_valid got=%0h exp=0", redir_valid_o); end
        @(negedge clk); clr(); invinstr_valid_i = 1'b1; invinstr_pc_i = 32'hC0;
        @(negedge clk); clr(); #1;
        total++; if (redir_pc_o !== 32'h80) begin bad++; $display("FAIL stall_hold_pc got=%0h exp=80", redir_pc_o); end
        total++; if (fetch_hold_o !== 1'b1) begin bad++; $display("FAIL stall_hold got=%0h exp=1", fetch_hold_o); end
        fetch_idle_i = 1'b1; #1;
        total++; if (redir_valid_o !== 1'b1) begin bad++; $display("FAIL stall_issue got=%0h exp=1", redir_valid_o); end
        total++; if (redir_src_o !== 2'd2) begin bad++; $display("FAIL stall_src got=%0h exp=2", redir_src_o); end
        total++; if (drop_cnt_o !== 8'd1) begin bad++; $display("FAIL stall_drop got=%0h exp=1", drop_cnt_o); end
        @(negedge clk); #1;
        total++; if (redir_valid_o !== 1'b0) begin bad++; $display("FAIL stall_once got=%0h exp=0", redir_valid_o); end
        total++; if (epoch_o !== 3'd1) begin bad++; $display("FAIL stall_epoch got=%0h exp=1", epoch_o); end
    endtask

    task automatic test_flush_replace();
        do_reset();
        @(negedge clk); fetch_idle_i = 1'b0;
        flush_valid_i = 1'b1; flush_pc_i = 32'h200; mispred_valid_i = 1'b1; mispred_pc_i = 32'h300;
        @(negedge clk); clr(); #1;
        total++; if (redir_pc_o !== 32'h200) begin bad++; $display("FAIL flush_first_pc got=%0h exp=200", redir_pc_o); end
        total++; if (drop_cnt_o !== 8'd1) begin bad++; $display("FAIL flush_drop1 got=%0h exp=1", drop_cnt_o); end
        flush_valid_i = 1'b1; flush_pc_i = 32'h400;
        @(negedge clk); clr(); fetch_idle_i = 1'b1; #1;
        total++; if (redir_valid_o !== 1'b1) begin bad++; $display("FAIL flush_issue got=%0h exp=1", redir_valid_o); end
        total++; if (redir_pc_o !== 32'h400) begin bad++; $display("FAIL flush_pc got=%0h exp=400", redir_pc_o); end
        total++; if (redir_src_o !== 2'd3) begin bad++; $display("FAIL flush_src got=%0h exp=3", redir_src_o); end
        total++; if (drop_cnt_o !== 8'd1) begin bad++; $display("FAIL flush_drop2 got=%0h exp=1", drop_cnt_o); end
    endtask

    task automatic test_issue_collide();
        do_reset();
        @(negedge clk); fetch_idle_i = 1'b0; flush_valid_i = 1'b1; flush_pc_i = 32'h500;
        @(negedge clk); clr(); fetch_idle_i = 1'b1; ret_valid_i = 1'b1; ret_pc_i = 32'h600; #1;
        total++; if (redir_pc_o !== 32'h500) begin bad++; $display("FAIL col1_pc got=%0h exp=500", redir_pc_o); end
        @(negedge clk); clr(); #1;
        total++; if (fetch_hold_o !== 1'b0) begin bad++; $display("FAIL col1_idle got=%0h exp=0", fetch_hold_o); end
        total++; if (drop_cnt_o !== 8'd1) begin bad++; $display("FAIL col1_drop got=%0h exp=1", drop_cnt_o); end
        do_reset();
        @(negedge clk); fetch_idle_i = 1'b0; ret_valid_i = 1'b1; ret_pc_i = 32'h700;
        @(negedge clk); clr(); fetch_idle_i = 1'b1; flush_valid_i = 1'b1; flush_pc_i = 32'h800; #1;
        total++; if (redir_src_o !== 2'd0 || redir_valid_o !== 1'b1) begin bad++; $display("FAIL col2_ret got=%0h/%0h exp=0/1", redir_src_o, redir_valid_o); end
        @(negedge clk); clr(); #1;
        total++; if (redir_valid_o !== 1'b1) begin bad++; $display("FAIL col2_valid got=%0h exp=1", redir_valid_o); end
        total++; if (redir_pc_o !== 32'h800) begin bad++; $display("FAIL col2_pc got=%0h exp=800", redir_pc_o); end
        total++; if (epoch_o !== 3'd1) begin bad++; $display("FAIL col2_epoch1 got=%0h exp=1", epoch_o); end
        @(negedge clk); #1;
        total++; if (epoch_o !== 3'd2) begin bad++; $display("FAIL col2_epoch2 got=%0h exp=2", epoch_o); end
        total++; if (drop_cnt_o !== 8'd0) begin bad++; $display("FAIL col2_drop got=%0h exp=0", drop_cnt_o); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_epoch [9];
        exp_epoch = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            clr(); fetch_idle_i = 1'b1;
            ret_valid_i = (k < 9); ret_pc_i = 32'h1000 + 32'(k * 4);
            #1;
            if (k >= 1 && k <= 9) begin
                total++; if (redir_valid_o !== 1'b1 || redir_pc_o !== 32'h1000 + 32'((k - 1) * 4)) begin bad++; $display("FAIL b2b_issue k=%0d got=%0h/%0h exp=1/%0h", k, redir_valid_o, redir_pc_o, 32'h1000 + 32'((k - 1) * 4)); end
            end
            if (k >= 2) begin
                total++; if (epoch_o !== exp_epoch[k-2]) begin bad++; $display("FAIL b2b_epoch k=%0d got=%0h exp=%0h", k, epoch_o, exp_epoch[k-2]); end
            end
        end
        total++; if (redir_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_end got=%0h exp=0", redir_valid_o); end
        clr();
    endtask

    task automatic test_drop_sat();
        do_reset();
        @(negedge clk); fetch_idle_i = 1'b0;
        flush_valid_i = 1'b1; mispred_valid_i = 1'b1; invinstr_valid_i = 1'b1; ret_valid_i = 1'b1;
        repeat (84) @(negedge clk);
        #1;
        total++; if (drop_cnt_o !== 8'd252) begin bad++; $display("FAIL sat_252 got=%0d exp=252", drop_cnt_o); end
        @(negedge clk); #1;
        total++; if (drop_cnt_o !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d exp=255", drop_cnt_o); end
        repeat (15) @(negedge clk);
        #1;
        total++; if (drop_cnt_o !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d exp=255", drop_cnt_o); end
        clr();
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk); fetch_idle_i = 1'b0; flush_valid_i = 1'b1; flush_pc_i = 32'h900;
        @(negedge clk); clr(); #1;
        total++; if (fetch_hold_o !== 1'b1) begin bad++; $display("FAIL mid_pending got=%0h exp=1", fetch_hold_o); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (fetch_hold_o !== 1'b0) begin bad++; $display("FAIL mid_hold got=%0h exp=0", fetch_hold_o); end
        fetch_idle_i = 1'b1; #1;
        total++; if (redir_valid_o !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0h exp=0", redir_valid_o); end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            total++; if (redir_valid_o !== 1'b0 || epoch_o !== 3'd0) begin bad++; $display("FAIL mid_after got=%0h/%0h exp=0/0", redir_valid_o, epoch_o); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall_replace();
        test_flush_replace();
        test_issue_collide();
        test_back_to_back();
        test_drop_sat();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
